uart_rx_frame_ctrl: RTL and testbench

Frame controller on the receive side of the UART: consumes the one-cycle byte strobe and data byte from the 8-bit UART receiver and sequences them through a framing state machine (sync, length, payload, checksum). Complete frames are committed to a stable output buffer. Framing, checksum and inter-byte timeout errors are flagged. The block sits between the UART receiver and the host/command logic, so downstream logic sees whole validated frames instead of raw bytes.

---
 rtl/uart_rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller (SYNC, LEN, payload, XOR checksum)
module uart_rx_frame_ctrl #(
   parameter int CLKS_PER_BIT = 217,
   parameter int MAX_LEN      = 16,
   parameter int TIMEOUT_CLKS = 10*10*CLKS_PER_BIT
) (
   input  logic       Clock_i,
   input  logic       Reset_i,
   input  logic       RX_Receive_i,
   input  logic [7:0] RX_Data_i,
   input  logic [3:0] Read_Addr_i,
   output logic [7:0] Read_Data_o,
   output logic       Frame_Valid_o,
   output logic       Frame_Error_o,
   output logic [1:0] Error_Code_o,
   output logic [4:0] Frame_Length_o,
   output logic       Busy_o
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
   // Counter reads 0 the cycle after a strobe, so expiring at this value
   // puts the error pulse TIMEOUT_CLKS-1 cycles after the last strobe.
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 3);

   typedef enum logic [1:0] {S_IDLE, S_LENGTH, S_PAYLOAD, S_CHECKSUM} state_t;

   state_t          state_q, state_d;
   logic [4:0]      len_q, len_d;
   logic [4:0]      widx_q, widx_d;
   logic [4:0]      flen_q, flen_d;
   logic [7:0]      chk_q, chk_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            valid_q, valid_d;
   logic            error_q, error_d;
   logic [1:0]      ecode_q, ecode_d;
   logic            wr_en, commit, timeout;
   logic [7:0]      wbuf_q [MAX_LEN];
   logic [7:0]      obuf_q [MAX_LEN];

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      chk_d   = chk_q;
      flen_d  = flen_q;
      tcnt_d  = '0;
      valid_d = 1'b0;
      error_d = 1'b0;
      ecode_d = ecode_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      timeout = (tcnt_q == TO_LAST);
      if (state_q != S_IDLE && !RX_Receive_i) tcnt_d = tcnt_q + TW'(1);
      case (state_q)
         S_IDLE: begin
            if (RX_Receive_i && RX_Data_i == SYNC) state_d = S_LENGTH;
         end
         S_LENGTH: begin
            if (RX_Receive_i) begin
               if (RX_Data_i != 8'd0 && RX_Data_i <= LEN_MAX) begin
                  len_d   = RX_Data_i[4:0];
                  chk_d   = RX_Data_i;
                  widx_d  = 5'd0;
                  state_d = S_PAYLOAD;
               end else begin
                  error_d = 1'b1;
                  ecode_d = 2'b01;
                  state_d = S_IDLE;
               end
            end else if (timeout) begin
               error_d = 1'b1;
               ecode_d = 2'b11;
               state_d = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (RX_Receive_i) begin
               wr_en  = 1'b1;
               chk_d  = chk_q ^ RX_Data_i;
               widx_d = widx_q + 5'd1;
               if (widx_q == len_q - 5'd1) state_d = S_CHECKSUM;
            end else if (timeout) begin
               error_d = 1'b1;
               ecode_d = 2'b11;
               state_d = S_IDLE;
            end
         end
         S_CHECKSUM: begin
            if (RX_Receive_i) begin
               state_d = S_IDLE;
               if (RX_Data_i == chk_q) begin
                  commit  = 1'b1;
                  valid_d = 1'b1;
                  flen_d  = len_q;
               end else begin
                  error_d = 1'b1;
                  ecode_d = 2'b10;
               end
            end else if (timeout) begin
               error_d = 1'b1;
               ecode_d = 2'b11;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) tcnt_d = '0;
   end

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q <= S_IDLE;
         len_q   <= 5'd0;
         widx_q  <= 5'd0;
         flen_q  <= 5'd0;
         chk_q   <= 8'd0;
         tcnt_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         ecode_q <= 2'b00;
         for (int i = 0; i < MAX_LEN; i++) obuf_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         flen_q  <= flen_d;
         chk_q   <= chk_d;
         tcnt_q  <= tcnt_d;
         valid_q <= valid_d;
         error_q <= error_d;
         ecode_q <= ecode_d;
         if (commit) begin
            for (int i = 0; i < MAX_LEN; i++)
               obuf_q[i] <= (5'(i) < len_q) ? wbuf_q[i] : 8'h00;
         end
      end
   end

   // Working buffer needs no reset: only bytes below LEN are ever committed.
   always_ff @(posedge Clock_i) begin
      if (wr_en) wbuf_q[widx_q[AW-1:0]] <= RX_Data_i;
   end

   always_comb begin
      Read_Data_o = 8'h00;
      if ({1'b0, Read_Addr_i} < 5'(MAX_LEN)) Read_Data_o = obuf_q[Read_Addr_i[AW-1:0]];
   end

   assign Frame_Valid_o  = valid_q;
   assign Frame_Error_o  = error_q;
   assign Error_Code_o   = ecode_q;
   assign Frame_Length_o = flen_q;
   assign Busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

   localparam int CPB  = 217;
   localparam int MAXL = 16;
   localparam int TO   = 10*10*CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drv_stb = 1'b0, ser_stb = 1'b0, ser_mode = 1'b0;
   logic [7:0] drv_data = 8'h00, ser_data = 8'h00;
   logic       rx_stb;
   logic [7:0] rx_data;
   logic [3:0] raddr = 4'd0;
   logic [7:0] rdata;
   logic       fv, fe, busy;
   logic [1:0] ecode;
   logic [4:0] flen;
   logic       txd = 1'b1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int last_stb = 0;
   int ser_last = 0;
   logic overlap = 1'b0;

   typedef struct {int kind; int cyc; logic [1:0] code;} ev_t;
   typedef struct {int kind; logic [1:0] code;} exp_t;
   ev_t  evq[$];
   exp_t exq[$];
   logic [7:0] stim_q[$];
   logic [7:0] m_buf [MAXL];
   int         m_len = 0;

   assign rx_stb  = ser_mode ? ser_stb  : drv_stb;
   assign rx_data = ser_mode ? ser_data : drv_data;

   uart_rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TO)) dut (
      .Clock_i(clk), .Reset_i(rst), .RX_Receive_i(rx_stb), .RX_Data_i(rx_data),
      .Read_Addr_i(raddr), .Read_Data_o(rdata), .Frame_Valid_o(fv), .Frame_Error_o(fe),
      .Error_Code_o(ecode), .Frame_Length_o(flen), .Busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fv && fe) overlap <= 1'b1;
      if (fv || fe) evq.push_back('{fv ? 1 : 2, cyc, ecode});
   end

   // Behavioural serial receiver: mid-bit sampling, strobe after the stop bit
   initial begin
      logic [7:0] rb;
      forever begin
         @(posedge clk); #1;
         if (ser_mode && txd === 1'b0) begin
            repeat (CPB/2) begin @(posedge clk); #1; end
            for (int b = 0; b < 8; b++) begin
               repeat (CPB) begin @(posedge clk); #1; end
               rb[b] = txd;
            end
            repeat (CPB) begin @(posedge clk); #1; end
            ser_data = rb; ser_stb = 1'b1; ser_last = cyc;
            @(posedge clk); #1;
            ser_stb = 1'b0;
         end
      end
   end

   task automatic sync_clk();
      @(posedge clk); #1;
   endtask

   task automatic put(input logic [7:0] b, input int gap);
      drv_data = b; drv_stb = 1'b1; last_stb = cyc;
      sync_clk();
      drv_stb = 1'b0;
      repeat (gap - 1) sync_clk();
   endtask

   task automatic uart_send(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         txd = fr[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic push_frame(input int len, input bit bad_chk);
      logic [7:0] x, p;
      x = 8'(len);
      stim_q.push_back(8'hA5);
      stim_q.push_back(8'(len));
      for (int k = 0; k < len; k++) begin
         p = 8'($urandom);
         x = x ^ p;
         stim_q.push_back(p);
      end
      stim_q.push_back(bad_chk ? (x ^ 8'(1 + $urandom_range(254))) : x);
   endtask

   // Reference: parse the whole byte stream as frames, recording outcomes
   function automatic void model_parse();
      int i;
      i = 0;
      while (i < stim_q.size()) begin
         if (stim_q[i] != 8'hA5) i++;
         else begin
            int L;
            logic [7:0] x;
            L = int'(stim_q[i+1]);
            if (L == 0 || L > MAXL) begin
               exq.push_back('{2, 2'b01});
               i += 2;
            end else begin
               x = stim_q[i+1];
               for (int k = 0; k < L; k++) x = x ^ stim_q[i+2+k];
               if (x == stim_q[i+2+L]) begin
                  exq.push_back('{1, 2'b00});
                  m_len = L;
                  for (int k = 0; k < MAXL; k++) m_buf[k] = (k < L) ? stim_q[i+2+k] : 8'h00;
               end else exq.push_back('{2, 2'b10});
               i += L + 3;
            end
         end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1; drv_data = 8'hA5; drv_stb = 1'b1;
      repeat (2) sync_clk();
      drv_stb = 1'b0;
      checks++; if (fv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fv); end
      checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", fe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (ecode !== 2'b00) begin errors++; $display("FAIL reset_code got %b exp 00", ecode); end
      checks++; if (flen !== 5'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", flen); end
      raddr = 4'd0; #1;
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rd0 got %h exp 00", rdata); end
      raddr = 4'd15; #1;
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rd15 got %h exp 00", rdata); end
      sync_clk();
      rst = 1'b0;
      sync_clk();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy got %b exp 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] fr [6];
      logic [7:0] exp_rd [4];
      fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
      evq.delete();
      for (int k = 0; k < 5; k++) put(fr[k], 2170);
      put(fr[5], 1);
      repeat (3) sync_clk();
      checks++; if (evq.size() !== 1) begin errors++; $display("FAIL basic_events got %0d exp 1", evq.size()); end
      if (evq.size() > 0) begin
         checks++; if (evq[0].kind !== 1) begin errors++; $display("FAIL basic_kind got %0d exp 1", evq[0].kind); end
         checks++; if (evq[0].cyc - last_stb !== 1) begin errors++; $display("FAIL basic_latency got %0d exp 1", evq[0].cyc - last_stb); end
      end
      checks++; if (flen !== 5'd3) begin errors++; $display("FAIL basic_len got %0d exp 3", flen); end
      for (int k = 0; k < 4; k++) begin
         raddr = 4'(k); #1;
         checks++; if (rdata !== exp_rd[k]) begin errors++; $display("FAIL basic_rd%0d got %h exp %h", k, rdata, exp_rd[k]); end
      end
      sync_clk();
   endtask

   task automatic test_bad_chk();
      logic [7:0] fr [5];
      logic [7:0] exp_rd [3];
      fr = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
      exp_rd = '{8'h11, 8'h22, 8'h33};
      evq.delete();
      for (int k = 0; k < 5; k++) put(fr[k], 3);
      checks++; if (evq.size() !== 1) begin errors++; $display("FAIL badchk_events got %0d exp 1", evq.size()); end
      if (evq.size() > 0) begin
         checks++; if (evq[0].kind !== 2) begin errors++; $display("FAIL badchk_kind got %0d exp 2", evq[0].kind); end
         checks++; if (evq[0].code !== 2'b10) begin errors++; $display("FAIL badchk_code got %b exp 10", evq[0].code); end
      end
      checks++; if (flen !== 5'd3) begin errors++; $display("FAIL badchk_len got %0d exp 3", flen); end
      for (int k = 0; k < 3; k++) begin
         raddr = 4'(k); #1;
         checks++; if (rdata !== exp_rd[k]) begin errors++; $display("FAIL badchk_rd%0d got %h exp %h", k, rdata, exp_rd[k]); end
      end
      sync_clk();
   endtask

   task automatic test_bad_len();
      evq.delete();
      put(8'hA5, 1); put(8'h00, 2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen0_busy got %b exp 0", busy); end
      put(8'hA5, 1); put(8'h11, 2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen17_busy got %b exp 0", busy); end
      checks++; if (evq.size() !== 2) begin errors++; $display("FAIL badlen_events got %0d exp 2", evq.size()); end
      foreach (evq[k]) begin
         checks++;
         if (evq[k].kind !== 2 || evq[k].code !== 2'b01) begin
            errors++; $display("FAIL badlen_ev%0d got kind %0d code %b exp kind 2 code 01", k, evq[k].kind, evq[k].code);
         end
      end
   endtask

   task automatic test_timeout();
      int c0, n;
      evq.delete();
      put(8'hA5, 1); put(8'h02, 1); put(8'h55, 1);
      c0 = last_stb; n = 0;
      while (evq.size() == 0 && n < TO + 20) begin sync_clk(); n++; end
      checks++; if (evq.size() !== 1) begin errors++; $display("FAIL timeout_events got %0d exp 1", evq.size()); end
      if (evq.size() > 0) begin
         checks++; if (evq[0].kind !== 2 || evq[0].code !== 2'b11) begin errors++; $display("FAIL timeout_kind got kind %0d code %b exp kind 2 code 11", evq[0].kind, evq[0].code); end
         checks++; if (evq[0].cyc - c0 !== TO - 1) begin errors++; $display("FAIL timeout_delay got %0d exp %0d", evq[0].cyc - c0, TO - 1); end
      end
      sync_clk();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
      evq.delete();
      put(8'hA5, 1); put(8'h02, 1); put(8'h55, 1);
      c0 = last_stb;
      while (cyc < c0 + TO - 2) sync_clk();
      put(8'h66, 4);
      checks++; if (evq.size() !== 0) begin errors++; $display("FAIL expiry_byte_events got %0d exp 0", evq.size()); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL expiry_byte_busy got %b exp 1", busy); end
      put(8'h31, 3);
      checks++; if (evq.size() !== 1 || (evq.size() > 0 && evq[0].kind !== 1)) begin errors++; $display("FAIL expiry_commit got %0d events exp 1 valid", evq.size()); end
      checks++; if (flen !== 5'd2) begin errors++; $display("FAIL expiry_len got %0d exp 2", flen); end
      raddr = 4'd1; #1;
      checks++; if (rdata !== 8'h66) begin errors++; $display("FAIL expiry_rd1 got %h exp 66", rdata); end
      sync_clk();
   endtask

   task automatic test_back_to_back();
      stim_q.delete(); exq.delete(); evq.delete();
      stim_q.push_back(8'h00); stim_q.push_back(8'hFF); stim_q.push_back(8'h5A);
      push_frame(2, 1'b1);
      push_frame(16, 1'b0);
      model_parse();
      foreach (stim_q[k]) put(stim_q[k], 1);
      repeat (3) sync_clk();
      checks++; if (evq.size() !== exq.size()) begin errors++; $display("FAIL b2b_events got %0d exp %0d", evq.size(), exq.size()); end
      for (int k = 0; k < evq.size() && k < exq.size(); k++) begin
         checks++;
         if (evq[k].kind !== exq[k].kind || (exq[k].kind == 2 && evq[k].code !== exq[k].code)) begin
            errors++; $display("FAIL b2b_ev%0d got kind %0d code %b exp kind %0d code %b", k, evq[k].kind, evq[k].code, exq[k].kind, exq[k].code);
         end
      end
      checks++; if (flen !== 5'd16) begin errors++; $display("FAIL b2b_len got %0d exp 16", flen); end
      for (int k = 0; k < MAXL; k++) begin
         raddr = 4'(k); #1;
         checks++; if (rdata !== m_buf[k]) begin errors++; $display("FAIL b2b_rd%0d got %h exp %h", k, rdata, m_buf[k]); end
      end
      sync_clk();
   endtask

   task automatic test_random();
      int t;
      logic [7:0] nz;
      stim_q.delete(); exq.delete(); evq.delete();
      for (int f = 0; f < 12; f++) begin
         repeat ($urandom_range(2)) begin
            nz = 8'($urandom);
            if (nz == 8'hA5) nz = 8'h5A;
            stim_q.push_back(nz);
         end
         t = $urandom_range(3);
         if (t == 3) begin
            stim_q.push_back(8'hA5);
            stim_q.push_back(($urandom_range(1) == 0) ? 8'h00 : 8'(17 + $urandom_range(238)));
         end else push_frame($urandom_range(MAXL, 1), t == 2);
      end
      model_parse();
      foreach (stim_q[k]) put(stim_q[k], $urandom_range(4, 1));
      repeat (3) sync_clk();
      checks++; if (evq.size() !== exq.size()) begin errors++; $display("FAIL rand_events got %0d exp %0d", evq.size(), exq.size()); end
      for (int k = 0; k < evq.size() && k < exq.size(); k++) begin
         checks++;
         if (evq[k].kind !== exq[k].kind || (exq[k].kind == 2 && evq[k].code !== exq[k].code)) begin
            errors++; $display("FAIL rand_ev%0d got kind %0d code %b exp kind %0d code %b", k, evq[k].kind, evq[k].code, exq[k].kind, exq[k].code);
         end
      end
      checks++; if (flen !== 5'(m_len)) begin errors++; $display("FAIL rand_len got %0d exp %0d", flen, m_len); end
      for (int k = 0; k < MAXL; k++) begin
         raddr = 4'(k); #1;
         checks++; if (rdata !== m_buf[k]) begin errors++; $display("FAIL rand_rd%0d got %h exp %h", k, rdata, m_buf[k]); end
      end
      sync_clk();
   endtask

   task automatic test_reset_mid();
      evq.delete();
      put(8'hA5, 1); put(8'h04, 1); put(8'h01, 1); put(8'h02, 1);
      rst = 1'b1;
      sync_clk();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      checks++; if (flen !== 5'd0) begin errors++; $display("FAIL rstmid_len got %0d exp 0", flen); end
      checks++; if (ecode !== 2'b00) begin errors++; $display("FAIL rstmid_code got %b exp 00", ecode); end
      raddr = 4'd0; #1;
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rd0 got %h exp 00", rdata); end
      sync_clk();
      checks++; if (evq.size() !== 0) begin errors++; $display("FAIL rstmid_events got %0d exp 0", evq.size()); end
      put(8'hA5, 1); put(8'h01, 1); put(8'h7E, 1); put(8'h7F, 3);
      checks++; if (evq.size() !== 1 || (evq.size() > 0 && evq[0].kind !== 1)) begin errors++; $display("FAIL rstmid_commit got %0d events exp 1 valid", evq.size()); end
      checks++; if (flen !== 5'd1) begin errors++; $display("FAIL rstmid_newlen got %0d exp 1", flen); end
      raddr = 4'd0; #1;
      checks++; if (rdata !== 8'h7E) begin errors++; $display("FAIL rstmid_newrd0 got %h exp 7e", rdata); end
      sync_clk();
   endtask

   task automatic test_serial();
      logic [7:0] fr [6];
      logic [7:0] exp_rd [4];
      int n;
      fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
      ser_mode = 1'b1;
      sync_clk();
      evq.delete();
      for (int k = 0; k < 6; k++) uart_send(fr[k]);
      sync_clk();
      n = 0;
      while (evq.size() == 0 && n < 50) begin sync_clk(); n++; end
      repeat (3) sync_clk();
      ser_mode = 1'b0;
      checks++; if (evq.size() !== 1) begin errors++; $display("FAIL serial_events got %0d exp 1", evq.size()); end
      if (evq.size() > 0) begin
         checks++; if (evq[0].kind !== 1) begin errors++; $display("FAIL serial_kind got %0d exp 1", evq[0].kind); end
         checks++; if (evq[0].cyc - ser_last !== 1) begin errors++; $display("FAIL serial_latency got %0d exp 1", evq[0].cyc - ser_last); end
      end
      checks++; if (flen !== 5'd3) begin errors++; $display("FAIL serial_len got %0d exp 3", flen); end
      for (int k = 0; k < 4; k++) begin
         raddr = 4'(k); #1;
         checks++; if (rdata !== exp_rd[k]) begin errors++; $display("FAIL serial_rd%0d got %h exp %h", k, rdata, exp_rd[k]); end
      end
      sync_clk();
   endtask

   initial begin
      sync_clk();
      test_reset();
      test_basic();
      test_bad_chk();
      test_bad_len();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_serial();
      checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL pulse_overlap got %b exp 0", overlap); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
